ex_mem_pipe: RTL and testbench

- Parametrised EX/MEM pipeline stage carrying ALU result, store data, destination register, branch target and MEM/WB control from Execute to Memory.
- Successor to the fixed 64-bit EX/MEM register. Adds a valid/ready handshake, a stall-tolerant two-entry skid buffer, synchronous flush (bubble insertion) and registered forwarding taps for the hazard unit.
- Sits between the ALU/branch-adder outputs and data memory plus the MEM/WB stage.

---
 rtl/riscv_pipe_pkg.sv | 23 ++
 rtl/pipe_skid_buf.sv | 98 +++++++++
 rtl/ex_mem_pipe.sv | 91 +++++++++
 tb/tb_ex_mem_pipe.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pipe_pkg.sv
// rtl/riscv_pipe_pkg.sv - shared pipeline types and defaults for the EX/MEM stage
package riscv_pipe_pkg;

    localparam int XLEN_DEFAULT   = 64;
    localparam int REG_AW_DEFAULT = 5;

    // MEM-stage and WB-stage controls carried alongside the data fields.
    typedef struct packed {
        logic branch;
        logic mem_read;
        logic mem_write;
        logic reg_write;
        logic mem_to_reg;
    } ex_mem_ctrl_t;

    // Number of entries held by the skid buffer.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pipe_state_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// rtl/pipe_skid_buf.sv - generic valid/ready skid buffer with flush
//
// Ports:
//   clk, reset (async, active-low), flush (sync kill of all entries)
//   in_valid / in_ready / in_data    : upstream side
//   out_valid / out_ready / out_data : downstream side, out_data is the head register
// SKID=1: head + skid register, in_ready registered (no out_ready -> in_ready path).
// SKID=0: head register only, in_ready = !out_valid | out_ready.
module pipe_skid_buf
    import riscv_pipe_pkg::*;
#(
    parameter int W    = 8,
    parameter int SKID = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    pipe_state_t  state, state_n;
    logic [W-1:0] head, skid;
    logic         rdy_q;
    logic         accept, consume;
    logic         load_h_in, load_h_skid, load_s;

    assign out_valid = (state != EMPTY);
    assign out_data  = head;

    // rdy_q is also the "out of reset" flag, so in_ready stays low while reset
    // is asserted in both modes.
    assign in_ready = (SKID != 0) ? rdy_q : (rdy_q & (!out_valid | out_ready));

    assign accept  = in_valid & in_ready;
    assign consume = out_valid & out_ready;

    always_comb begin
        state_n     = state;
        load_h_in   = 1'b0;
        load_h_skid = 1'b0;
        load_s      = 1'b0;
        if (flush) begin
            state_n = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state_n   = ONE;
                        load_h_in = 1'b1;
                    end
                end
                ONE: begin
                    if (accept && consume) begin
                        load_h_in = 1'b1;
                    end else if (accept) begin
                        state_n = TWO;
                        load_s  = 1'b1;
                    end else if (consume) begin
                        state_n = EMPTY;
                    end
                end
                TWO: begin
                    if (consume) begin
                        state_n     = ONE;
                        load_h_skid = 1'b1;
                    end
                end
                default: state_n = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= EMPTY;
            head  <= '0;
            skid  <= '0;
            rdy_q <= 1'b0;
        end else begin
            state <= state_n;
            rdy_q <= (state_n != TWO);
            if (load_h_in) begin
                head <= in_data;
            end else if (load_h_skid) begin
                head <= skid;
            end
            if (load_s) begin
                skid <= in_data;
            end
        end
    end

endmodule

// File: rtl/ex_mem_pipe.sv
// rtl/ex_mem_pipe.sv - EX/MEM pipeline stage with handshake, flush and forwarding taps
//
// Ports:
//   clk, reset (async, active-low), flush
//   in_valid/in_ready, in_zero, in_result, in_wdata, in_rd, in_target, in_<ctrl> : from EX
//   out_valid/out_ready, out_zero, out_result, out_wdata, out_rd, out_target,
//   out_<ctrl>, out_pc_src                                                    : to MEM
//   fwd_rd, fwd_en                                                            : hazard unit taps
module ex_mem_pipe
    import riscv_pipe_pkg::*;
#(
    parameter int XLEN   = XLEN_DEFAULT,
    parameter int REG_AW = REG_AW_DEFAULT,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_zero,
    input  logic [XLEN-1:0]   in_result,
    input  logic [XLEN-1:0]   in_wdata,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [XLEN-1:0]   in_target,
    input  logic              in_branch,
    input  logic              in_mem_read,
    input  logic              in_mem_write,
    input  logic              in_reg_write,
    input  logic              in_mem_to_reg,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_zero,
    output logic [XLEN-1:0]   out_result,
    output logic [XLEN-1:0]   out_wdata,
    output logic [REG_AW-1:0] out_rd,
    output logic [XLEN-1:0]   out_target,
    output logic              out_branch,
    output logic              out_mem_read,
    output logic              out_mem_write,
    output logic              out_reg_write,
    output logic              out_mem_to_reg,
    output logic              out_pc_src,
    output logic [REG_AW-1:0] fwd_rd,
    output logic              fwd_en
);

    localparam int PW = 1 + 3 * XLEN + REG_AW + $bits(ex_mem_ctrl_t);

    ex_mem_ctrl_t  in_ctrl, head_ctrl;
    logic [PW-1:0] in_pay, head_pay;

    assign in_ctrl = '{branch:     in_branch,
                       mem_read:   in_mem_read,
                       mem_write:  in_mem_write,
                       reg_write:  in_reg_write,
                       mem_to_reg: in_mem_to_reg};

    assign in_pay = {in_zero, in_result, in_wdata, in_rd, in_target, in_ctrl};

    pipe_skid_buf #(
        .W    (PW),
        .SKID (SKID)
    ) u_buf (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_pay),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (head_pay)
    );

    // Data fields come straight from the head register (stale in a bubble).
    assign {out_zero, out_result, out_wdata, out_rd, out_target, head_ctrl} = head_pay;

    // Controls are gated so a bubble can never write memory or the register file.
    assign out_branch     = out_valid & head_ctrl.branch;
    assign out_mem_read   = out_valid & head_ctrl.mem_read;
    assign out_mem_write  = out_valid & head_ctrl.mem_write;
    assign out_reg_write  = out_valid & head_ctrl.reg_write;
    assign out_mem_to_reg = out_valid & head_ctrl.mem_to_reg;

    assign out_pc_src = out_branch & out_zero;
    assign fwd_rd     = out_rd;
    // x0 is hard-wired zero, so it must never be forwarded.
    assign fwd_en     = out_reg_write & (out_rd != '0);

endmodule

// File: tb/tb_ex_mem_pipe.sv
// tb/tb_ex_mem_pipe.sv - self-checking bench for ex_mem_pipe
module tb_ex_mem_pipe;

    typedef struct packed {
        logic        zero;
        logic [63:0] result;
        logic [63:0] wdata;
        logic [4:0]  rd;
        logic [63:0] target;
        logic        branch;
        logic        mem_read;
        logic        mem_write;
        logic        reg_write;
        logic        mem_to_reg;
    } ent_t;

    typedef struct {
        ent_t e;
        logic exp_pc_src;
        logic exp_fwd_en;
    } vec_t;

    logic clk = 1'b0;
    logic reset, flush, in_valid, out_ready, in_valid0, out_ready0;
    ent_t cur;

    logic        in_ready, out_valid, out_zero, out_branch, out_mem_read, out_mem_write;
    logic        out_reg_write, out_mem_to_reg, out_pc_src, fwd_en;
    logic [63:0] out_result, out_wdata, out_target;
    logic [4:0]  out_rd, fwd_rd;

    logic        in_ready0, out_valid0, out_zero0, out_branch0, out_mem_read0, out_mem_write0;
    logic        out_reg_write0, out_mem_to_reg0, out_pc_src0, fwd_en0;
    logic [63:0] out_result0, out_wdata0, out_target0;
    logic [4:0]  out_rd0, fwd_rd0;

    int   pass_cnt = 0;
    int   total_cnt = 0;
    ent_t sb[$];
    vec_t vecs[6];

    always #5 clk = ~clk;

    ex_mem_pipe #(.XLEN(64), .REG_AW(5), .SKID(1)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_zero(cur.zero), .in_result(cur.result), .in_wdata(cur.wdata),
        .in_rd(cur.rd), .in_target(cur.target),
        .in_branch(cur.branch), .in_mem_read(cur.mem_read), .in_mem_write(cur.mem_write),
        .in_reg_write(cur.reg_write), .in_mem_to_reg(cur.mem_to_reg),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_zero(out_zero), .out_result(out_result), .out_wdata(out_wdata),
        .out_rd(out_rd), .out_target(out_target),
        .out_branch(out_branch), .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
        .out_reg_write(out_reg_write), .out_mem_to_reg(out_mem_to_reg),
        .out_pc_src(out_pc_src), .fwd_rd(fwd_rd), .fwd_en(fwd_en)
    );

    ex_mem_pipe #(.XLEN(64), .REG_AW(5), .SKID(0)) dut0 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid0), .in_ready(in_ready0),
        .in_zero(cur.zero), .in_result(cur.result), .in_wdata(cur.wdata),
        .in_rd(cur.rd), .in_target(cur.target),
        .in_branch(cur.branch), .in_mem_read(cur.mem_read), .in_mem_write(cur.mem_write),
        .in_reg_write(cur.reg_write), .in_mem_to_reg(cur.mem_to_reg),
        .out_valid(out_valid0), .out_ready(out_ready0),
        .out_zero(out_zero0), .out_result(out_result0), .out_wdata(out_wdata0),
        .out_rd(out_rd0), .out_target(out_target0),
        .out_branch(out_branch0), .out_mem_read(out_mem_read0), .out_mem_write(out_mem_write0),
        .out_reg_write(out_reg_write0), .out_mem_to_reg(out_mem_to_reg0),
        .out_pc_src(out_pc_src0), .fwd_rd(fwd_rd0), .fwd_en(fwd_en0)
    );

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic ent_t act_ent();
        return '{zero: out_zero, result: out_result, wdata: out_wdata, rd: out_rd,
                 target: out_target, branch: out_branch, mem_read: out_mem_read,
                 mem_write: out_mem_write, reg_write: out_reg_write,
                 mem_to_reg: out_mem_to_reg};
    endfunction

    function automatic logic [255:0] all_out();
        return {out_valid, out_zero, out_result, out_wdata, out_rd, out_target, out_branch,
                out_mem_read, out_mem_write, out_reg_write, out_mem_to_reg, out_pc_src,
                fwd_rd, fwd_en};
    endfunction

    function automatic logic [6:0] ctl_out();
        return {out_branch, out_mem_read, out_mem_write, out_reg_write, out_mem_to_reg,
                out_pc_src, fwd_en};
    endfunction

    function automatic ent_t mk(input logic [63:0] res, input logic [4:0] rd,
                                input logic [4:0] ctl, input logic z, input logic [63:0] tgt);
        return '{zero: z, result: res, wdata: ~res, rd: rd, target: tgt,
                 branch: ctl[4], mem_read: ctl[3], mem_write: ctl[2],
                 reg_write: ctl[1], mem_to_reg: ctl[0]};
    endfunction

    // One clock of the main DUT: transfers are judged at the negedge, the
    // scoreboard pops on consume and pushes on accept, flush empties it.
    task automatic cycle(output bit acc, output bit con);
        ent_t exp;
        @(negedge clk);
        acc = in_valid && in_ready;
        con = out_valid && out_ready;
        if (flush) begin
            sb.delete();
        end else begin
            if (con) begin
                if (sb.size() == 0) begin
                    total_cnt++;
                    $display("FAIL sb_unexpected: got result %0h expected no entry", out_result);
                end else begin
                    exp = sb.pop_front();
                    chk("sb_entry", act_ent(), exp);
                end
            end
            if (acc) sb.push_back(cur);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit a, c;
        int idx;
        vecs[0] = '{mk(64'h10, 5'd1, 5'b10000, 1'b1, 64'h2040), 1'b1, 1'b0};
        vecs[1] = '{mk(64'h11, 5'd1, 5'b10000, 1'b0, 64'h2040), 1'b0, 1'b0};
        vecs[2] = '{mk(64'h12, 5'd0, 5'b00010, 1'b0, 64'h0),    1'b0, 1'b0};
        vecs[3] = '{mk(64'h13, 5'd31, 5'b01011, 1'b0, 64'h0),   1'b0, 1'b1};
        vecs[4] = '{mk(64'h14, 5'd7, 5'b00100, 1'b1, 64'h0),    1'b0, 1'b0};
        vecs[5] = '{mk(64'h15, 5'd3, 5'b00010, 1'b1, 64'h88),   1'b0, 1'b1};

        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_valid0 = 1'b0; out_ready0 = 1'b0; cur = '0;
        #2;
        chk("reset_outputs", all_out(), 256'h0);
        chk("reset_in_ready", in_ready, 1'b0);
        chk("reset_in_ready_skid0", in_ready0, 1'b0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_in_ready", in_ready, 1'b1);
        chk("post_reset_out_valid", out_valid, 1'b0);

        // Single entry, one cycle latency, then a bubble.
        cur = mk(64'h1000, 5'd5, 5'b00010, 1'b0, 64'h0);
        in_valid = 1'b1; out_ready = 1'b1;
        cycle(a, c);
        in_valid = 1'b0;
        chk("single_valid", out_valid, 1'b1);
        chk("single_result", out_result, 64'h1000);
        chk("single_fwd_rd", fwd_rd, 5'd5);
        chk("single_fwd_en", fwd_en, 1'b1);
        cycle(a, c);
        chk("bubble_valid", out_valid, 1'b0);
        chk("bubble_fwd_en", fwd_en, 1'b0);

        // Table of single entries: derived outputs.
        for (int i = 0; i < 6; i++) begin
            cur = vecs[i].e; in_valid = 1'b1; out_ready = 1'b1;
            cycle(a, c);
            in_valid = 1'b0;
            chk($sformatf("vec%0d_pc_src", i), out_pc_src, vecs[i].exp_pc_src);
            chk($sformatf("vec%0d_fwd_en", i), fwd_en, vecs[i].exp_fwd_en);
            chk($sformatf("vec%0d_target", i), out_target, vecs[i].e.target);
            cycle(a, c);
        end

        // Back-to-back stream against a stalled consumer.
        out_ready = 1'b0; idx = 0;
        for (int cyc = 0; cyc < 20 && (idx < 4 || sb.size() != 0); cyc++) begin
            in_valid = (idx < 4);
            cur = mk(64'(idx + 1), 5'd2, 5'b00010, 1'b0, 64'h0);
            if (cyc == 2) begin
                chk("stream_in_ready_low", in_ready, 1'b0);
                chk("stream_accepted_two", idx, 2);
                out_ready = 1'b1;
            end
            if (cyc >= 2) chk("stream_no_gap", out_valid, sb.size() != 0);
            cycle(a, c);
            if (a) idx++;
        end
        in_valid = 1'b0;
        chk("stream_all_sent", idx, 4);
        chk("stream_drained", sb.size(), 0);

        // Flush with a simultaneous input, from ONE and from TWO.
        for (int n = 1; n <= 2; n++) begin
            out_ready = 1'b0;
            for (int k = 0; k < n; k++) begin
                cur = mk(64'(32 + k), 5'd3, 5'b10010, 1'b1, 64'h40);
                in_valid = 1'b1;
                cycle(a, c);
            end
            cur = mk(64'h9, 5'd3, 5'b10010, 1'b1, 64'h40);
            flush = 1'b1;
            cycle(a, c);
            flush = 1'b0; in_valid = 1'b0;
            chk($sformatf("flush%0d_valid", n), out_valid, 1'b0);
            chk($sformatf("flush%0d_ctl", n), ctl_out(), 7'h0);
            chk($sformatf("flush%0d_in_ready", n), in_ready, 1'b1);
            out_ready = 1'b1;
            for (int k = 0; k < 3; k++) begin
                cycle(a, c);
                chk($sformatf("flush%0d_no_9", n), out_valid, 1'b0);
            end
        end

        // Asynchronous reset while holding two entries.
        out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            cur = mk(64'(64 + k), 5'd4, 5'b10010, 1'b1, 64'h80);
            in_valid = 1'b1;
            cycle(a, c);
        end
        in_valid = 1'b0;
        chk("two_in_ready_low", in_ready, 1'b0);
        @(negedge clk); #2;
        reset = 1'b0;
        #1;
        chk("async_reset_outputs", all_out(), 256'h0);
        chk("async_reset_in_ready", in_ready, 1'b0);
        sb.delete();
        @(posedge clk); #2;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("after_async_in_ready", in_ready, 1'b1);
        chk("after_async_valid", out_valid, 1'b0);

        // SKID=0: combinational in_ready, simultaneous accept and consume.
        cur = mk(64'hA1, 5'd6, 5'b00010, 1'b0, 64'h0);
        in_valid0 = 1'b1; out_ready0 = 1'b0;
        @(posedge clk); #1;
        cur = mk(64'hA2, 5'd6, 5'b00010, 1'b0, 64'h0);
        #1;
        chk("s0_head_valid", out_valid0, 1'b1);
        chk("s0_head_result", out_result0, 64'hA1);
        chk("s0_in_ready_low", in_ready0, 1'b0);
        out_ready0 = 1'b1;
        #1;
        chk("s0_in_ready_comb", in_ready0, 1'b1);
        @(posedge clk); #1;
        chk("s0_swap_valid", out_valid0, 1'b1);
        chk("s0_swap_result", out_result0, 64'hA2);
        in_valid0 = 1'b0;
        @(posedge clk); #1;
        chk("s0_drained", out_valid0, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
